// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Default 640x480@60 raster timing, axis total derivation and
//                the shared screen-coordinate type.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    // Largest axis total the 10-bit coordinate ports can represent.
    localparam int unsigned c_coord_limit = 1024;

    localparam int unsigned c_h_active = 640;
    localparam int unsigned c_h_fp     = 16;
    localparam int unsigned c_h_sync   = 96;
    localparam int unsigned c_h_bp     = 48;

    localparam int unsigned c_v_active = 480;
    localparam int unsigned c_v_fp     = 10;
    localparam int unsigned c_v_sync   = 2;
    localparam int unsigned c_v_bp     = 33;

    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned c_h_total = axis_total(c_h_active, c_h_fp, c_h_sync, c_h_bp);
    localparam int unsigned c_v_total = axis_total(c_v_active, c_v_fp, c_v_sync, c_v_bp);

endpackage : vga_timing_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Wrap-around position counter for one raster axis, with
//                active/sync window decode of the value it will hold next.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = c_h_active,
    parameter int unsigned FP     = c_h_fp,
    parameter int unsigned SYNC   = c_h_sync,
    parameter int unsigned BP     = c_h_bp
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    output logic [9:0] o_count,
    output logic       o_wrap,
    output logic       o_next_active,
    output logic       o_next_sync
);

    localparam int unsigned c_total      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam coord_t      c_last       = coord_t'(c_total - 1);
    localparam logic [10:0] c_active_end = 11'(ACTIVE);
    localparam logic [10:0] c_sync_start = 11'(ACTIVE + FP);
    localparam logic [10:0] c_sync_end   = 11'(ACTIVE + FP + SYNC);

    if (c_total > c_coord_limit) begin : g_total_check
        $error("vga_axis_counter: axis total %0d exceeds %0d", c_total, c_coord_limit);
    end

    coord_t      r_count;
    coord_t      w_next;
    logic        w_at_last;
    logic [10:0] w_next_ext;

    assign w_at_last = (r_count == c_last);

    always_comb begin
        w_next = r_count;
        if (i_en) begin
            w_next = w_at_last ? '0 : r_count + coord_t'(1);
        end
    end

    // Reset parks on the last position so the first enabled edge lands on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= c_last;
        end else begin
            r_count <= w_next;
        end
    end

    assign w_next_ext    = {1'b0, w_next};
    assign o_count       = r_count;
    assign o_wrap        = i_en && w_at_last;
    assign o_next_active = (w_next_ext < c_active_end);
    assign o_next_sync   = (w_next_ext >= c_sync_start) && (w_next_ext < c_sync_end);

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_signals.sv
`default_nettype none
// ============================================================================
//  Module      : vga_signals
//  Description : VGA raster timing generator producing beam position, sync
//                pulses and display enable, all registered in the pixel clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_signals
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = c_h_active,
    parameter int unsigned H_FP     = c_h_fp,
    parameter int unsigned H_SYNC   = c_h_sync,
    parameter int unsigned H_BP     = c_h_bp,
    parameter int unsigned V_ACTIVE = c_v_active,
    parameter int unsigned V_FP     = c_v_fp,
    parameter int unsigned V_SYNC   = c_v_sync,
    parameter int unsigned V_BP     = c_v_bp,
    parameter logic        H_POL    = 1'b0,
    parameter logic        V_POL    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_pixel,
    output logic [9:0] sx,
    output logic [9:0] sy,
    output logic       hsync,
    output logic       vsync,
    output logic       de
);

    logic [9:0] w_h_count;
    logic [9:0] w_v_count;
    logic       w_h_wrap;
    logic       w_v_wrap_unused;
    logic       w_h_next_active;
    logic       w_h_next_sync;
    logic       w_v_next_active;
    logic       w_v_next_sync;

    logic       r_hsync;
    logic       r_vsync;
    logic       r_de;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_counter (
        .clk           (clk),
        .rst_n         (rst_pixel),
        .i_en          (1'b1),
        .o_count       (w_h_count),
        .o_wrap        (w_h_wrap),
        .o_next_active (w_h_next_active),
        .o_next_sync   (w_h_next_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_counter (
        .clk           (clk),
        .rst_n         (rst_pixel),
        .i_en          (w_h_wrap),
        .o_count       (w_v_count),
        .o_wrap        (w_v_wrap_unused),
        .o_next_active (w_v_next_active),
        .o_next_sync   (w_v_next_sync)
    );

    // Decoding the counters' next values keeps these flops aligned with sx/sy.
    always_ff @(posedge clk or negedge rst_pixel) begin
        if (!rst_pixel) begin
            r_hsync <= ~H_POL;
            r_vsync <= ~V_POL;
            r_de    <= 1'b0;
        end else begin
            r_hsync <= w_h_next_sync ? H_POL : ~H_POL;
            r_vsync <= w_v_next_sync ? V_POL : ~V_POL;
            r_de    <= w_h_next_active && w_v_next_active;
        end
    end

    assign sx    = w_h_count;
    assign sy    = w_v_count;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign de    = r_de;

endmodule : vga_signals
`default_nettype wire

// File: tb/tb_vga_signals.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_signals
//  Description : Self-checking bench for vga_signals at default, tiny and
//                inverted-polarity timings against an arithmetic raster model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_vga_signals;

    localparam int N_DUT = 3;

    logic clk = 1'b0;
    logic rst_pixel = 1'b1;
    always #5 clk = ~clk;

    // Timing sets: 0 = default 640x480, 1 = tiny 12x7, 2 = 80x56 with active-high syncs.
    int ha [N_DUT] = '{640, 8, 64};
    int hf [N_DUT] = '{16, 1, 4};
    int hw [N_DUT] = '{96, 2, 8};
    int hb [N_DUT] = '{48, 1, 4};
    int va [N_DUT] = '{480, 4, 48};
    int vf [N_DUT] = '{10, 1, 2};
    int vw [N_DUT] = '{2, 1, 2};
    int vb [N_DUT] = '{33, 1, 4};
    int hp [N_DUT] = '{0, 0, 1};
    int vp [N_DUT] = '{0, 0, 1};

    logic [9:0] sx0, sy0, sx1, sy1, sx2, sy2;
    logic       hs0, vs0, de0, hs1, vs1, de1, hs2, vs2, de2;

    vga_signals u_dut_default (
        .clk (clk), .rst_pixel (rst_pixel),
        .sx (sx0), .sy (sy0), .hsync (hs0), .vsync (vs0), .de (de0)
    );

    vga_signals #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .H_POL (1'b0), .V_POL (1'b0)
    ) u_dut_small (
        .clk (clk), .rst_pixel (rst_pixel),
        .sx (sx1), .sy (sy1), .hsync (hs1), .vsync (vs1), .de (de1)
    );

    vga_signals #(
        .H_ACTIVE (64), .H_FP (4), .H_SYNC (8), .H_BP (4),
        .V_ACTIVE (48), .V_FP (2), .V_SYNC (2), .V_BP (4),
        .H_POL (1'b1), .V_POL (1'b1)
    ) u_dut_pol (
        .clk (clk), .rst_pixel (rst_pixel),
        .sx (sx2), .sy (sy2), .hsync (hs2), .vsync (vs2), .de (de2)
    );

    logic [22:0] obs [N_DUT];
    assign obs[0] = {sx0, sy0, hs0, vs0, de0};
    assign obs[1] = {sx1, sy1, hs1, vs1, de1};
    assign obs[2] = {sx2, sy2, hs2, vs2, de2};

    int     checks = 0;
    int     errors = 0;
    longint n_cyc  = -1;   // clock edges since reset release; -1 while in reset

    function automatic longint h_total(input int k);
        return longint'(ha[k] + hf[k] + hw[k] + hb[k]);
    endfunction

    function automatic longint v_total(input int k);
        return longint'(va[k] + vf[k] + vw[k] + vb[k]);
    endfunction

    // Raster position is simply the edge count folded by the line and frame sizes.
    function automatic logic [22:0] model(input int k, input longint n);
        longint ht, vt, f, x, y;
        logic   hs_o, vs_o, de_o;
        ht = h_total(k);
        vt = v_total(k);
        if (n < 0) begin
            x    = ht - 1;
            y    = vt - 1;
            hs_o = (hp[k] == 0);
            vs_o = (vp[k] == 0);
            de_o = 1'b0;
        end else begin
            f    = n % (ht * vt);
            x    = f % ht;
            y    = f / ht;
            hs_o = ((x >= ha[k] + hf[k]) && (x < ha[k] + hf[k] + hw[k])) ? (hp[k] != 0) : (hp[k] == 0);
            vs_o = ((y >= va[k] + vf[k]) && (y < va[k] + vf[k] + vw[k])) ? (vp[k] != 0) : (vp[k] == 0);
            de_o = (x < ha[k]) && (y < va[k]);
        end
        return {10'(x), 10'(y), hs_o, vs_o, de_o};
    endfunction

    function automatic string fmt(input logic [22:0] v);
        return $sformatf("sx=%0d sy=%0d hs=%b vs=%b de=%b", v[22:13], v[12:3], v[2], v[1], v[0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_pixel) n_cyc = n_cyc + 1;
    endtask

    // Reset is always moved between clock edges (sample point +3ns).
    task automatic assert_reset_mid();
        #3 rst_pixel = 1'b0;
        n_cyc = -1;
        #1;
    endtask

    task automatic release_reset_mid();
        #3 rst_pixel = 1'b1;
        step();
    endtask

    task automatic test_reset();
        #2 rst_pixel = 1'b0;
        n_cyc = -1;
        repeat (5) step();
        for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if (obs[k] !== model(k, -1)) begin
                errors++;
                $display("FAIL reset_state dut%0d: got %s, expected %s", k, fmt(obs[k]), fmt(model(k, -1)));
            end
        end
        release_reset_mid();
        for (int k = 0; k < N_DUT; k++) begin
            checks++;
            if (obs[k] !== model(k, 0) || obs[k][22:3] !== 20'd0 || obs[k][0] !== 1'b1) begin
                errors++;
                $display("FAIL reset_release dut%0d: got %s, expected %s", k, fmt(obs[k]), fmt(model(k, 0)));
            end
        end
    endtask

    task automatic test_line();
        int de_cnt, hs_cnt, hs_first, hs_last;
        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, n_cyc)) begin
                    errors++;
                    $display("FAIL line dut%0d n=%0d: got %s, expected %s", k, n_cyc, fmt(obs[k]), fmt(model(k, n_cyc)));
                end
            end
            if (de0) de_cnt++;
            if (!hs0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(sx0);
                hs_last = int'(sx0);
            end
            step();
        end
        checks++;
        if (de_cnt != 640) begin
            errors++;
            $display("FAIL line_de_count: got %0d, expected 640", de_cnt);
        end
        checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            errors++;
            $display("FAIL line_hsync_window: got %0d clocks at %0d..%0d, expected 96 at 656..751", hs_cnt, hs_first, hs_last);
        end
        checks++;
        if (sx0 !== 10'd0 || sy0 !== 10'd1) begin
            errors++;
            $display("FAIL line_wrap: got sx=%0d sy=%0d, expected sx=0 sy=1", sx0, sy0);
        end
    endtask

    task automatic test_frame();
        int de_cnt [N_DUT];
        int vs_cnt [N_DUT];
        int hs_cnt [N_DUT];
        for (int k = 0; k < N_DUT; k++) begin
            de_cnt[k] = 0; vs_cnt[k] = 0; hs_cnt[k] = 0;
        end
        assert_reset_mid();
        step();
        release_reset_mid();
        for (int i = 0; i < 4480; i++) begin
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, n_cyc)) begin
                    errors++;
                    $display("FAIL frame dut%0d n=%0d: got %s, expected %s", k, n_cyc, fmt(obs[k]), fmt(model(k, n_cyc)));
                end
                if (n_cyc < h_total(k) * v_total(k)) begin
                    if (obs[k][0]) de_cnt[k]++;
                    if (obs[k][1] == (vp[k] != 0)) vs_cnt[k]++;
                    if (obs[k][2] == (hp[k] != 0)) hs_cnt[k]++;
                end
            end
            step();
        end
        for (int k = 1; k < N_DUT; k++) begin
            checks++;
            if (de_cnt[k] != ha[k] * va[k]) begin
                errors++;
                $display("FAIL frame_de_count dut%0d: got %0d, expected %0d", k, de_cnt[k], ha[k] * va[k]);
            end
            checks++;
            if (longint'(vs_cnt[k]) != longint'(vw[k]) * h_total(k)) begin
                errors++;
                $display("FAIL frame_vsync_count dut%0d: got %0d, expected %0d", k, vs_cnt[k], longint'(vw[k]) * h_total(k));
            end
            checks++;
            if (longint'(hs_cnt[k]) != longint'(hw[k]) * v_total(k)) begin
                errors++;
                $display("FAIL frame_hsync_count dut%0d: got %0d, expected %0d", k, hs_cnt[k], longint'(hw[k]) * v_total(k));
            end
        end
        checks++;
        if (sx2 !== 10'd0 || sy2 !== 10'd0) begin
            errors++;
            $display("FAIL frame_end dut2: got sx=%0d sy=%0d, expected 0 0", sx2, sy2);
        end
    endtask

    task automatic test_wrap();
        longint ht, last_active_end, frame_end;
        ht = h_total(2);
        last_active_end = longint'(va[2] - 1) * ht + ht - 1;
        frame_end       = h_total(2) * v_total(2) - 1;
        assert_reset_mid();
        step();
        release_reset_mid();
        while (n_cyc < frame_end) begin
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, n_cyc)) begin
                    errors++;
                    $display("FAIL wrap_run dut%0d n=%0d: got %s, expected %s", k, n_cyc, fmt(obs[k]), fmt(model(k, n_cyc)));
                end
            end
            if (n_cyc == last_active_end) begin
                step();
                checks++;
                if (sx2 !== 10'd0 || sy2 !== 10'(va[2]) || de2 !== 1'b0) begin
                    errors++;
                    $display("FAIL wrap_active_end: got sx=%0d sy=%0d de=%b, expected sx=0 sy=%0d de=0", sx2, sy2, de2, va[2]);
                end
            end else begin
                step();
            end
        end
        checks++;
        if (sx2 !== 10'(ht - 1) || sy2 !== 10'(v_total(2) - 1)) begin
            errors++;
            $display("FAIL wrap_last_pixel: got sx=%0d sy=%0d, expected %0d %0d", sx2, sy2, ht - 1, v_total(2) - 1);
        end
        step();
        checks++;
        if (sx2 !== 10'd0 || sy2 !== 10'd0 || de2 !== 1'b1) begin
            errors++;
            $display("FAIL wrap_frame: got sx=%0d sy=%0d de=%b, expected 0 0 1", sx2, sy2, de2);
        end
    endtask

    task automatic test_async_reset();
        longint target;
        int     hold;
        assert_reset_mid();
        step();
        release_reset_mid();
        for (int it = 0; it < 5; it++) begin
            target = (it == 0) ? longint'(2 * 800 + 300) : longint'($urandom_range(1, 3000));
            while (n_cyc < target) begin
                for (int k = 0; k < N_DUT; k++) begin
                    checks++;
                    if (obs[k] !== model(k, n_cyc)) begin
                        errors++;
                        $display("FAIL async_run dut%0d n=%0d: got %s, expected %s", k, n_cyc, fmt(obs[k]), fmt(model(k, n_cyc)));
                    end
                end
                step();
            end
            if (it == 0) begin
                checks++;
                if (sx0 !== 10'd300 || sy0 !== 10'd2) begin
                    errors++;
                    $display("FAIL async_position: got sx=%0d sy=%0d, expected 300 2", sx0, sy0);
                end
            end
            assert_reset_mid();
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, -1)) begin
                    errors++;
                    $display("FAIL async_immediate dut%0d: got %s, expected %s", k, fmt(obs[k]), fmt(model(k, -1)));
                end
            end
            hold = int'($urandom_range(1, 4));
            repeat (hold) step();
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, -1)) begin
                    errors++;
                    $display("FAIL async_hold dut%0d: got %s, expected %s", k, fmt(obs[k]), fmt(model(k, -1)));
                end
            end
            release_reset_mid();
            for (int k = 0; k < N_DUT; k++) begin
                checks++;
                if (obs[k] !== model(k, 0)) begin
                    errors++;
                    $display("FAIL async_restart dut%0d: got %s, expected %s", k, fmt(obs[k]), fmt(model(k, 0)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vga_signals
`default_nettype wire
